// File: rtl/vp_pkg.sv
// Shared widths, bank-select encoding and pass-through field layout for the
// vector pipeline register-read stage.
package vp_pkg;

    localparam int SW   = 21;
    localparam int VW   = 192;
    localparam int NREG = 16;
    localparam int AW   = 4;

    localparam int WB_WE_BIT = 0;

    typedef enum logic {
        BANK_SCALAR = 1'b0,
        BANK_VECTOR = 1'b1
    } bank_e;

    typedef struct packed {
        logic [AW-1:0] dest;
        logic          dest_type;
        logic [1:0]    wb;
    } rr_fields_t;

    function automatic logic bank_is_vector(input logic bank);
        return (bank == BANK_VECTOR);
    endfunction

endpackage

// File: rtl/rr_scoreboard.sv
// Pending-write scoreboard for the scalar and vector banks: one bit per register,
// a set port, a clear port and a three-register hazard query.
module rr_scoreboard
#(
    parameter int NREG = vp_pkg::NREG,
    parameter int AW   = vp_pkg::AW
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic              set_type,
    input  logic [AW-1:0]     set_reg,
    input  logic              clr_en,
    input  logic              clr_type,
    input  logic [AW-1:0]     clr_reg,
    input  logic              q1_type,
    input  logic [AW-1:0]     q1_reg,
    input  logic              q2_type,
    input  logic [AW-1:0]     q2_reg,
    input  logic              q3_en,
    input  logic              q3_type,
    input  logic [AW-1:0]     q3_reg,
    output logic [2*NREG-1:0] busy,
    output logic              hazard
);
    import vp_pkg::*;

    localparam int NB = 2 * NREG;

    logic [NB-1:0] busy_q;
    logic [NB-1:0] busy_d;
    logic [NB-1:0] set_mask_s;
    logic [NB-1:0] clr_mask_s;
    logic [NB-1:0] live_s;
    logic          hit1_s;
    logic          hit2_s;
    logic          hit3_s;

    // Scalar bank occupies the low half of the flat vector, vector bank the high half.
    function automatic logic [NB-1:0] reg_mask(input logic en, input logic bank,
                                               input logic [AW-1:0] regno);
        logic [NB-1:0] m;
        int            idx;
        m = {NB{1'b0}};
        if (bank_is_vector(bank)) begin
            idx = NREG + int'(regno);
        end else begin
            idx = int'(regno);
        end
        if (en) begin
            m = {{(NB-1){1'b0}}, 1'b1} << idx;
        end else begin
            m = {NB{1'b0}};
        end
        return m;
    endfunction

    // A writeback landing this cycle already releases its register for the query.
    always_comb begin
        set_mask_s = reg_mask(set_en, set_type, set_reg);
        clr_mask_s = reg_mask(clr_en, clr_type, clr_reg);
        live_s     = busy_q & ~clr_mask_s;
        hit1_s     = |(live_s & reg_mask(1'b1, q1_type, q1_reg));
        hit2_s     = |(live_s & reg_mask(1'b1, q2_type, q2_reg));
        hit3_s     = |(live_s & reg_mask(q3_en, q3_type, q3_reg));
        hazard     = hit1_s | hit2_s | hit3_s;
        busy_d     = live_s | set_mask_s;
    end

    // Pending bits; the set is applied after the clear so a same-cycle set wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= {NB{1'b0}};
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/reg_read_stage.sv
// Register-read pipeline stage: hazard-gated accept, writeback forwarding into the
// operands, and a single registered output slot with a valid/ready handshake.
module reg_read_stage
#(
    parameter int SW   = vp_pkg::SW,
    parameter int VW   = vp_pkg::VW,
    parameter int NREG = vp_pkg::NREG
)
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [$clog2(NREG)-1:0]    in_src1,
    input  logic [$clog2(NREG)-1:0]    in_src2,
    input  logic [$clog2(NREG)-1:0]    in_dest,
    input  logic                       in_src1Type,
    input  logic                       in_src2Type,
    input  logic                       in_destType,
    input  logic [1:0]                 in_wb,
    output logic [$clog2(NREG)-1:0]    rd1_addr,
    output logic [$clog2(NREG)-1:0]    rd2_addr,
    input  logic [SW-1:0]              r1e,
    input  logic [SW-1:0]              r2e,
    input  logic [VW-1:0]              r1v,
    input  logic [VW-1:0]              r2v,
    input  logic                       wb_we,
    input  logic [$clog2(NREG)-1:0]    wb_dest,
    input  logic                       wb_destType,
    input  logic [SW-1:0]              wbEscalar,
    input  logic [VW-1:0]              wbVector,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [VW-1:0]              out_opA,
    output logic [VW-1:0]              out_opB,
    output logic [$clog2(NREG)-1:0]    out_dest,
    output logic                       out_destType,
    output logic [1:0]                 out_wb,
    output logic [2*NREG-1:0]          sb_busy
);
    import vp_pkg::*;

    localparam int RAW = $clog2(NREG);

    logic          hazard_s;
    logic          in_ready_s;
    logic          accept_s;
    logic          set_en_s;
    logic          fwd1_s;
    logic          fwd2_s;
    logic [VW-1:0] opa_s;
    logic [VW-1:0] opb_s;

    logic          out_valid_q;
    logic          out_valid_d;
    logic [VW-1:0] opa_q;
    logic [VW-1:0] opa_d;
    logic [VW-1:0] opb_q;
    logic [VW-1:0] opb_d;
    rr_fields_t    fields_q;
    rr_fields_t    fields_d;

    function automatic logic [VW-1:0] pick_operand(input logic fwd, input logic bank,
                                                   input logic [SW-1:0] rf_s,
                                                   input logic [VW-1:0] rf_v,
                                                   input logic [SW-1:0] wb_s,
                                                   input logic [VW-1:0] wb_v);
        logic [VW-1:0] v;
        v = {VW{1'b0}};
        if (bank_is_vector(bank)) begin
            if (fwd) begin
                v = wb_v;
            end else begin
                v = rf_v;
            end
        end else begin
            if (fwd) begin
                v = {{(VW-SW){1'b0}}, wb_s};
            end else begin
                v = {{(VW-SW){1'b0}}, rf_s};
            end
        end
        return v;
    endfunction

    rr_scoreboard #(
        .NREG (NREG),
        .AW   (RAW)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (set_en_s),
        .set_type (in_destType),
        .set_reg  (in_dest),
        .clr_en   (wb_we),
        .clr_type (wb_destType),
        .clr_reg  (wb_dest),
        .q1_type  (in_src1Type),
        .q1_reg   (in_src1),
        .q2_type  (in_src2Type),
        .q2_reg   (in_src2),
        .q3_en    (in_wb[WB_WE_BIT]),
        .q3_type  (in_destType),
        .q3_reg   (in_dest),
        .busy     (sb_busy),
        .hazard   (hazard_s)
    );

    // Handshake: the output slot frees up in the same cycle it is drained.
    always_comb begin
        in_ready_s = !hazard_s && (!out_valid_q || out_ready);
        accept_s   = in_valid && in_ready_s;
        set_en_s   = accept_s && in_wb[WB_WE_BIT];
    end

    // Operand selection with bypass of the writeback that lands this cycle.
    always_comb begin
        fwd1_s = wb_we && (wb_dest == in_src1) && (wb_destType == in_src1Type);
        fwd2_s = wb_we && (wb_dest == in_src2) && (wb_destType == in_src2Type);
        opa_s  = pick_operand(fwd1_s, in_src1Type, r1e, r1v, wbEscalar, wbVector);
        opb_s  = pick_operand(fwd2_s, in_src2Type, r2e, r2v, wbEscalar, wbVector);
    end

    // Next state of the output slot; data only moves on accept.
    always_comb begin
        out_valid_d = out_valid_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        fields_d    = fields_q;
        if (accept_s) begin
            out_valid_d        = 1'b1;
            opa_d              = opa_s;
            opb_d              = opb_s;
            fields_d.dest      = in_dest;
            fields_d.dest_type = in_destType;
            fields_d.wb        = in_wb;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output register; reset drops any held instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            opa_q       <= {VW{1'b0}};
            opb_q       <= {VW{1'b0}};
            fields_q    <= '{dest: {AW{1'b0}}, dest_type: 1'b0, wb: 2'b00};
        end else begin
            out_valid_q <= out_valid_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            fields_q    <= fields_d;
        end
    end

    assign in_ready     = in_ready_s;
    assign rd1_addr     = in_src1;
    assign rd2_addr     = in_src2;
    assign out_valid    = out_valid_q;
    assign out_opA      = opa_q;
    assign out_opB      = opb_q;
    assign out_dest     = fields_q.dest;
    assign out_destType = fields_q.dest_type;
    assign out_wb       = fields_q.wb;

endmodule
